// File: rtl/lfsr_seq_ctrl_if.sv
// Handshake bundle for lfsr_seq_ctrl: tap-index configuration beats and the
// generated-bit stream. The controller uses the slave modport.
interface lfsr_seq_ctrl_if;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_tap;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready;

  modport master (
    output cfg_valid, cfg_tap, bit_ready,
    input  cfg_ready, bit_out, bit_valid
  );

  modport slave (
    input  cfg_valid, cfg_tap, bit_ready,
    output cfg_ready, bit_out, bit_valid
  );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the XORs tap-feedback datapath: owns the tap vector (co_buf)
// and the shift register, loads taps beat by beat, loads a seed, and streams
// generated bits over a valid/ready handshake.
// Optional build macro: LFSR_LOCKUP_DET_EN (all-zero register lockup detection).
module lfsr_seq_ctrl #(
  parameter int unsigned NUM_OF_TAPS = 15,
  parameter int unsigned REG_WIDTH   = 16,
  parameter int unsigned XOR_LAT     = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     res,
  lfsr_seq_ctrl_if.slave           bus,
  input  logic                     seed_load,
  input  logic [REG_WIDTH-1:0]     seed,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_bits,
  output logic [NUM_OF_TAPS*8-1:0] co_buf,
  output logic [REG_WIDTH-1:0]     register,
  input  logic                     xor_result,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int unsigned TAP_W = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_EMIT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]               state_q, state_d;
  logic [TAP_W-1:0]         tap_cnt_q, tap_cnt_d;
  logic [CNT_W-1:0]         bit_cnt_q, bit_cnt_d;
  logic [NUM_OF_TAPS*8-1:0] co_buf_d;
  logic [REG_WIDTH-1:0]     register_d;
  logic [REG_WIDTH-1:0]     reg_shift;
  logic                     cfg_acc;
  logic                     cfg_ready_d, bit_out_d, bit_valid_d;
  logic                     busy_d, done_d, err_d;

  // Next-state and next-value logic for every registered output
  always_comb begin
    state_d    = state_q;
    tap_cnt_d  = tap_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    co_buf_d   = co_buf;
    register_d = register;
    bit_out_d  = bus.bit_out;
    err_d      = err;
    cfg_acc    = bus.cfg_valid && bus.cfg_ready;
    reg_shift  = {register[REG_WIDTH-2:0], bus.bit_out};

    case (state_q)
      S_IDLE, S_LOAD: begin
        if (cfg_acc) begin
          for (int unsigned k = 0; k < NUM_OF_TAPS; k++) begin
            if (tap_cnt_q == TAP_W'(k)) co_buf_d[8*k +: 8] = bus.cfg_tap;
          end
          if (32'(bus.cfg_tap) >= REG_WIDTH) err_d = 1'b1;
          if (tap_cnt_q == TAP_W'(NUM_OF_TAPS - 1)) begin
            tap_cnt_d = '0;
            state_d   = S_IDLE;
          end else begin
            tap_cnt_d = tap_cnt_q + 1'b1;
            state_d   = S_LOAD;
          end
        end else if (state_q == S_IDLE) begin
          if (start) begin
            err_d = 1'b0;
            if (num_bits == '0) begin
              state_d = S_DONE;
            end else begin
              bit_cnt_d = num_bits;
              // Zero-latency XORs: register is unchanged by start, so the
              // first bit can be taken straight away.
              if (XOR_LAT == 0) begin
                bit_out_d = xor_result;
                state_d   = S_EMIT;
              end else begin
                state_d   = S_WAIT;
              end
            end
`ifdef LFSR_LOCKUP_DET_EN
            if (register == '0) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end
`endif
          end else if (seed_load) begin
            register_d = seed;
          end
        end
      end
      S_WAIT: begin
        bit_out_d = xor_result;
        state_d   = S_EMIT;
      end
      S_EMIT: begin
        if (bus.bit_ready) begin
          register_d = reg_shift;
          bit_cnt_d  = bit_cnt_q - 1'b1;
          state_d    = (bit_cnt_q == CNT_W'(1)) ? S_DONE : S_WAIT;
`ifdef LFSR_LOCKUP_DET_EN
          if (reg_shift == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Ready drops for one cycle after the final tap beat
    cfg_ready_d = (state_d == S_LOAD) || ((state_d == S_IDLE) && !cfg_acc);
    bit_valid_d = (state_d == S_EMIT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q       <= S_IDLE;
      tap_cnt_q     <= '0;
      bit_cnt_q     <= '0;
      co_buf        <= '0;
      register      <= '0;
      bus.cfg_ready <= 1'b0;
      bus.bit_out   <= 1'b0;
      bus.bit_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state_q       <= state_d;
      tap_cnt_q     <= tap_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      co_buf        <= co_buf_d;
      register      <= register_d;
      bus.cfg_ready <= cfg_ready_d;
      bus.bit_out   <= bit_out_d;
      bus.bit_valid <= bit_valid_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
    end
  end

endmodule
